// File: rtl/wb_timer.sv
// wb_timer: Wishbone B4 classic slave with a prescaled 64-bit mtime counter, a 64-bit
// compare register and a registered level interrupt; MTIME_HI reads return a tear-free shadow.
module wb_timer #(
   parameter int                        PRESCALE_WIDTH = 16,
   parameter logic [PRESCALE_WIDTH-1:0] PRESCALE_RESET = {PRESCALE_WIDTH{1'b0}}
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic [2:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        irq_o
);

   localparam logic [2:0] ADR_MTIME_LO = 3'd0;
   localparam logic [2:0] ADR_MTIME_HI = 3'd1;
   localparam logic [2:0] ADR_CMP_LO   = 3'd2;
   localparam logic [2:0] ADR_CMP_HI   = 3'd3;
   localparam logic [2:0] ADR_CTRL     = 3'd4;
   localparam logic [2:0] ADR_STATUS   = 3'd5;
   localparam logic [2:0] ADR_PRESCALE = 3'd6;

   logic                      ack_r;
   logic [31:0]               dat_r;
   logic                      irq_r;
   logic [63:0]               mtime_r;
   logic [63:0]               cmp_r;
   logic [1:0]                ctrl_r;
   logic                      pending_r;
   logic [PRESCALE_WIDTH-1:0] prescale_r;
   logic [PRESCALE_WIDTH-1:0] cnt_r;
   logic [31:0]               shadow_r;

   logic                      req_s;
   logic                      wr_s;
   logic                      rd_s;
   logic                      tick_s;
   logic                      match_s;
   logic                      clear_s;
   logic [31:0]               live_s;
   logic [31:0]               rdata_s;
   logic [31:0]               merged_s;
   logic [63:0]               mtime_nxt_s;
   logic [PRESCALE_WIDTH-1:0] cnt_nxt_s;
   logic                      pending_nxt_s;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      end
      return res;
   endfunction

   assign req_s   = wb_cyc_i & wb_stb_i & ~ack_r;
   assign wr_s    = req_s & wb_we_i;
   assign rd_s    = req_s & ~wb_we_i;
   assign tick_s  = ctrl_r[0] && (cnt_r == prescale_r);
   assign match_s = (mtime_r >= cmp_r);
   assign clear_s = wr_s && (wb_adr_i == ADR_STATUS) && wb_sel_i[0] && wb_dat_i[0];

   // Register decode: live value (write merge base) and bus read value; HI reads see the shadow.
   always_comb begin
      live_s  = 32'd0;
      rdata_s = 32'd0;
      case (wb_adr_i)
         ADR_MTIME_LO: begin live_s = mtime_r[31:0];  rdata_s = mtime_r[31:0];  end
         ADR_MTIME_HI: begin live_s = mtime_r[63:32]; rdata_s = shadow_r;       end
         ADR_CMP_LO:   begin live_s = cmp_r[31:0];    rdata_s = cmp_r[31:0];    end
         ADR_CMP_HI:   begin live_s = cmp_r[63:32];   rdata_s = cmp_r[63:32];   end
         ADR_CTRL:     begin live_s = {30'd0, ctrl_r}; rdata_s = {30'd0, ctrl_r}; end
         ADR_STATUS:   begin live_s = {31'd0, pending_r}; rdata_s = {31'd0, pending_r}; end
         ADR_PRESCALE: begin live_s = 32'(prescale_r); rdata_s = 32'(prescale_r); end
         default:      begin live_s = 32'd0;          rdata_s = 32'd0;          end
      endcase
      merged_s = byte_merge(live_s, wb_dat_i, wb_sel_i);
   end

   // Next-state for prescaler, mtime (bus write beats a same-cycle tick) and pending (set wins).
   always_comb begin
      cnt_nxt_s     = cnt_r;
      mtime_nxt_s   = mtime_r;
      pending_nxt_s = pending_r;
      if (wr_s && (wb_adr_i == ADR_PRESCALE)) begin
         cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
      end else if (!ctrl_r[0] || tick_s) begin
         cnt_nxt_s = {PRESCALE_WIDTH{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + PRESCALE_WIDTH'(1);
      end
      if (wr_s && (wb_adr_i == ADR_MTIME_LO)) begin
         mtime_nxt_s = {mtime_r[63:32], merged_s};
      end else if (wr_s && (wb_adr_i == ADR_MTIME_HI)) begin
         mtime_nxt_s = {merged_s, mtime_r[31:0]};
      end else if (tick_s) begin
         mtime_nxt_s = mtime_r + 64'd1;
      end else begin
         mtime_nxt_s = mtime_r;
      end
      if (match_s) begin
         pending_nxt_s = 1'b1;
      end else if (clear_s) begin
         pending_nxt_s = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
   end

   // Bus handshake: single-cycle ack, read data and MTIME_HI shadow capture.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack_r    <= 1'b0;
         dat_r    <= 32'd0;
         shadow_r <= 32'd0;
      end else begin
         ack_r <= req_s;
         dat_r <= rd_s ? rdata_s : 32'd0;
         if (rd_s && (wb_adr_i == ADR_MTIME_LO)) begin
            shadow_r <= mtime_r[63:32];
         end
      end
   end

   // Software-written configuration registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cmp_r      <= 64'hFFFF_FFFF_FFFF_FFFF;
         ctrl_r     <= 2'b00;
         prescale_r <= PRESCALE_RESET;
      end else if (wr_s) begin
         case (wb_adr_i)
            ADR_CMP_LO:   cmp_r[31:0]  <= merged_s;
            ADR_CMP_HI:   cmp_r[63:32] <= merged_s;
            ADR_CTRL:     ctrl_r       <= merged_s[1:0];
            ADR_PRESCALE: prescale_r   <= merged_s[PRESCALE_WIDTH-1:0];
            default:      ;
         endcase
      end
   end

   // Timer state and registered interrupt.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cnt_r     <= {PRESCALE_WIDTH{1'b0}};
         mtime_r   <= 64'd0;
         pending_r <= 1'b0;
         irq_r     <= 1'b0;
      end else begin
         cnt_r     <= cnt_nxt_s;
         mtime_r   <= mtime_nxt_s;
         pending_r <= pending_nxt_s;
         irq_r     <= pending_r & ctrl_r[1];
      end
   end

   assign wb_dat_o = dat_r;
   assign wb_ack_o = ack_r;
   assign wb_err_o = 1'b0;
   assign irq_o    = irq_r;

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed + randomized bench for wb_timer; mtime is predicted arithmetically
// from the enable edge and prescale value, other registers from a byte-merge model.
module tb_wb_timer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  adr;
   logic [31:0] dat_i;
   logic [3:0]  sel;
   logic        we, cyc, stb;
   logic [31:0] dat_o;
   logic        ack, err, irq;

   int errors = 0;
   int checks = 0;
   int ecount = 0;
   int last_edge;

   logic [63:0] m_base;
   int          m_start;
   int          m_p;
   bit          m_en;
   logic [63:0] cmp_m;

   wb_timer #(.PRESCALE_WIDTH(16), .PRESCALE_RESET(16'd0)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
      .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
      .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err), .irq_o(irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecount <= ecount + 1;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mtime value after edge n: one increment every (prescale+1) edges since the enable edge
   function automatic logic [63:0] mt_at(input int n);
      if (m_en) return m_base + 64'((n - m_start) / (m_p + 1));
      else return m_base;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
      return r;
   endfunction

   task automatic xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
      @(negedge clk);
      adr = a; we = w; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
      #1 chk("ack_before_edge", ack, 1'b0);
      @(posedge clk);
      #1 last_edge = ecount;
      chk("ack_high", ack, 1'b1);
      rd = dat_o;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk);
      #1 chk("ack_one_cycle", ack, 1'b0);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      xfer(a, 1'b1, d, s, dummy);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      xfer(a, 1'b0, 32'd0, 4'hF, d);
   endtask

   task automatic freeze();
      wr(3'd4, 32'd0, 4'hF);
      m_base = mt_at(last_edge);
      m_en   = 1'b0;
   endtask

   task automatic start(input int p, input logic [1:0] c);
      wr(3'd6, 32'(p), 4'hF);
      m_p = p;
      wr(3'd4, {30'd0, c}, 4'hF);
      m_start = last_edge;
      m_en    = c[0];
   endtask

   task automatic set_mtime(input logic [63:0] v);
      wr(3'd0, v[31:0], 4'hF);
      wr(3'd1, v[63:32], 4'hF);
      m_base = v;
   endtask

   initial begin
      logic [31:0] v, lo, hi, d;
      logic [63:0] e;
      logic [2:0]  a;
      logic [3:0]  s;
      int          p, got, rise_edge;

      rst_n = 1'b0; adr = 3'd0; dat_i = 32'd0; sel = 4'h0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
      m_base = 64'd0; m_start = 0; m_p = 0; m_en = 1'b0; cmp_m = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) @(posedge clk);
      #1 chk("rst_ack", ack, 1'b0);
      chk("rst_irq", irq, 1'b0);
      chk("rst_dat", dat_o, 32'd0);
      chk("err_tied", err, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      rd(3'd2, v); chk("rst_cmp_lo", v, 32'hFFFF_FFFF);
      rd(3'd3, v); chk("rst_cmp_hi", v, 32'hFFFF_FFFF);
      rd(3'd0, v); chk("rst_mtime_lo", v, 32'd0);
      rd(3'd4, v); chk("rst_ctrl", v, 32'd0);
      rd(3'd5, v); chk("rst_status", v, 32'd0);
      rd(3'd6, v); chk("rst_prescale", v, 32'd0);

      // byte-select writes and reserved address
      wr(3'd2, 32'hAABB_CCDD, 4'b0010);
      cmp_m[31:0] = merge(cmp_m[31:0], 32'hAABB_CCDD, 4'b0010);
      rd(3'd2, v); chk("cmp_lo_sel", v, 32'hFFFF_CCFF);
      wr(3'd7, 32'h1234_5678, 4'hF);
      rd(3'd7, v); chk("reserved_read", v, 32'd0);
      for (int i = 0; i < 5; i++) begin
         a = 3'(2 + $urandom_range(0, 1));
         d = $urandom;
         s = 4'($urandom_range(0, 15));
         wr(a, d, s);
         if (a == 3'd2) cmp_m[31:0] = merge(cmp_m[31:0], d, s);
         else cmp_m[63:32] = merge(cmp_m[63:32], d, s);
         rd(3'd2, v); chk("cmp_lo_rand", v, cmp_m[31:0]);
         rd(3'd3, v); chk("cmp_hi_rand", v, cmp_m[63:32]);
      end
      wr(3'd4, 32'hFFFF_FFFC, 4'hF);
      rd(3'd4, v); chk("ctrl_unused_bits", v, 32'd0);

      // prescaled counting, first pass PRESCALE=3 over 40 idle cycles
      for (int it = 0; it < 6; it++) begin
         p = (it == 0) ? 3 : int'($urandom_range(0, 6));
         freeze();
         start(p, 2'b01);
         repeat ((it == 0) ? 40 : int'($urandom_range(3, 40))) @(posedge clk);
         rd(3'd0, lo);
         e = mt_at(last_edge - 1);
         rd(3'd1, hi);
         chk("mtime_lo_count", lo, e[31:0]);
         chk("mtime_hi_shadow", hi, e[63:32]);
      end

      // 32-bit carry into the high word: the high read must pair with the low read
      freeze();
      set_mtime(64'h0000_0000_FFFF_FFFE);
      start(0, 2'b01);
      for (int k = 0; k < 4; k++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         rd(3'd0, lo);
         e = mt_at(last_edge - 1);
         rd(3'd1, hi);
         chk("wrap_lo", lo, e[31:0]);
         chk("wrap_hi", hi, e[63:32]);
      end

      // compare match, interrupt latency, W1C against an active match, rearm
      freeze();
      wr(3'd2, 32'h0000_0020, 4'hF);
      wr(3'd3, 32'd0, 4'hF);
      set_mtime(64'd0);
      wr(3'd5, 32'd1, 4'hF);
      rd(3'd5, v); chk("status_cleared", v, 32'd0);
      start(0, 2'b11);
      rise_edge = m_start + 34;
      got = -1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1 if (irq) begin
            got = ecount;
            break;
         end
      end
      chk("irq_rise_edge", 64'(got), 64'(rise_edge));
      wr(3'd5, 32'd1, 4'h1);
      rd(3'd5, v); chk("w1c_while_match", v, 32'd1);
      chk("irq_held", irq, 1'b1);
      wr(3'd3, 32'hFFFF_FFFF, 4'hF);
      wr(3'd2, 32'h0000_1000, 4'hF);
      wr(3'd3, 32'd0, 4'hF);
      wr(3'd5, 32'd1, 4'h1);
      chk("irq_after_rearm", irq, 1'b0);
      rd(3'd5, v); chk("status_after_rearm", v, 32'd0);

      // IRQ_EN gates the output only
      wr(3'd2, 32'd0, 4'hF);
      @(posedge clk);
      #1 chk("irq_cmp_zero", irq, 1'b1);
      wr(3'd4, 32'd1, 4'hF);
      chk("irq_en_off", irq, 1'b0);
      rd(3'd5, v); chk("pending_retained", v, 32'd1);
      wr(3'd4, 32'd3, 4'hF);
      chk("irq_en_on", irq, 1'b1);

      // asynchronous reset in the middle of an acked read with irq asserted
      @(negedge clk);
      adr = 3'd5; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(posedge clk);
      #1 chk("mid_ack", ack, 1'b1);
      chk("mid_irq", irq, 1'b1);
      #1 rst_n = 1'b0;
      #1 chk("async_ack", ack, 1'b0);
      chk("async_irq", irq, 1'b0);
      chk("async_dat", dat_o, 32'd0);
      cyc = 1'b0; stb = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_base = 64'd0; m_en = 1'b0; cmp_m = 64'hFFFF_FFFF_FFFF_FFFF;
      rd(3'd2, v); chk("post_cmp_lo", v, cmp_m[31:0]);
      rd(3'd3, v); chk("post_cmp_hi", v, cmp_m[63:32]);
      rd(3'd0, v); chk("post_mtime_lo", v, 32'd0);
      rd(3'd1, v); chk("post_mtime_hi", v, 32'd0);
      rd(3'd4, v); chk("post_ctrl", v, 32'd0);
      rd(3'd5, v); chk("post_status", v, 32'd0);
      rd(3'd6, v); chk("post_prescale", v, 32'd0);
      chk("post_irq", irq, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
